// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand feeder.
package systolic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } state_e;

    // Flat element offset of [r][c] in a row-major n x n matrix.
    function automatic int elem_idx(int r, int c, int n);
        return r * n + c;
    endfunction

    function automatic int feed_steps(int n);
        return 2 * n - 1;
    endfunction

    function automatic int drain_steps(int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/skew_lane_sel.sv
// Selects the element a skewed lane presents at a given step, or zero when out of window.
module skew_lane_sel #(
    parameter int WIDTH = 8,
    parameter int N     = 3,
    parameter int CW    = 4,
    parameter int LANE  = 0
) (
    input  logic [CW-1:0]      step_i,
    input  logic [N*WIDTH-1:0] elems_i,
    output logic [WIDTH-1:0]   elem_o,
    output logic               vld_o
);

    int step_int;
    assign step_int = int'(step_i);

    always_comb begin
        elem_o = '0;
        vld_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (step_int == LANE + k) begin
                elem_o = elems_i[k*WIDTH +: WIDTH];
                vld_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Captures NxN A and B operands and streams them diagonally skewed into a systolic array.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 HOLD,
    input  logic [N*N*WIDTH-1:0] A_IN,
    input  logic [N*N*WIDTH-1:0] B_IN,
    output logic [N*WIDTH-1:0]   A_OUT,
    output logic [N*WIDTH-1:0]   B_OUT,
    output logic [N-1:0]         A_VLD,
    output logic [N-1:0]         B_VLD,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int CW = $clog2(3 * N);
    localparam logic [CW-1:0] FeedLast  = CW'(feed_steps(N) - 1);
    // The flush runs one edge past the N-1 partial-product steps so DONE lands in cycle 3N.
    localparam logic [CW-1:0] DrainLast = CW'(drain_steps(N));

    state_e                 state_q, state_d;
    logic [CW-1:0]          step_q, step_d;
    logic [N*N*WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [N*WIDTH-1:0]     a_out_q, a_out_d, b_out_q, b_out_d;
    logic [N-1:0]           a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic                   busy_q, busy_d, done_q, done_d;

    logic [N*WIDTH-1:0]     a_sel, b_sel;
    logic [N-1:0]           a_sel_vld, b_sel_vld;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [N*WIDTH-1:0] b_col;

        for (genvar k = 0; k < N; k++) begin : g_col
            assign b_col[k*WIDTH +: WIDTH] = b_q[elem_idx(k, i, N)*WIDTH +: WIDTH];
        end

        skew_lane_sel #(
            .WIDTH(WIDTH),
            .N    (N),
            .CW   (CW),
            .LANE (i)
        ) u_a_sel (
            .step_i (step_q),
            .elems_i(a_q[elem_idx(i, 0, N)*WIDTH +: N*WIDTH]),
            .elem_o (a_sel[i*WIDTH +: WIDTH]),
            .vld_o  (a_sel_vld[i])
        );

        skew_lane_sel #(
            .WIDTH(WIDTH),
            .N    (N),
            .CW   (CW),
            .LANE (i)
        ) u_b_sel (
            .step_i (step_q),
            .elems_i(b_col),
            .elem_o (b_sel[i*WIDTH +: WIDTH]),
            .vld_o  (b_sel_vld[i])
        );
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        a_vld_d = a_vld_q;
        b_vld_d = b_vld_q;
        busy_d  = (state_q != StIdle);
        done_d  = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                a_out_d = '0;
                b_out_d = '0;
                a_vld_d = '0;
                b_vld_d = '0;
                // BUSY still shows the DONE cycle; a START seen then is not a new request.
                if (START && !busy_q) begin
                    a_d     = A_IN;
                    b_d     = B_IN;
                    step_d  = '0;
                    state_d = StFeed;
                end
            end
            StFeed: begin
                if (!HOLD) begin
                    a_out_d = a_sel;
                    b_out_d = b_sel;
                    a_vld_d = a_sel_vld;
                    b_vld_d = b_sel_vld;
                    if (step_q == FeedLast) begin
                        step_d  = '0;
                        state_d = StDrain;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (!HOLD) begin
                    a_out_d = '0;
                    b_out_d = '0;
                    a_vld_d = '0;
                    b_vld_d = '0;
                    if (step_q == DrainLast) begin
                        step_d  = '0;
                        state_d = StDone;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            StDone: begin
                a_out_d = '0;
                b_out_d = '0;
                a_vld_d = '0;
                b_vld_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
            a_vld_q <= '0;
            b_vld_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign A_OUT = a_out_q;
    assign B_OUT = b_out_q;
    assign A_VLD = a_vld_q;
    assign B_VLD = b_vld_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: an N=3/4-bit and an N=4/8-bit instance against a timeline model.
module tb_systolic_skew_feeder;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         st3 = 1'b0, hd3 = 1'b0, st4 = 1'b0, hd4 = 1'b0;
    logic [35:0]  a3_in = '0, b3_in = '0;
    logic [127:0] a4_in = '0, b4_in = '0;
    logic [11:0]  a3_out, b3_out;
    logic [31:0]  a4_out, b4_out;
    logic [2:0]   a3_vld, b3_vld;
    logic [3:0]   a4_vld, b4_vld;
    logic         busy3, done3, busy4, done4;

    int passed = 0;
    int total  = 0;

    // Model: per instance, whether an operation is live, its progress count and captured operands.
    bit mact[2];
    int mp[2];
    int ma[2][4][4];
    int mb[2][4][4];

    systolic_skew_feeder #(.WIDTH(4), .N(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .START(st3), .HOLD(hd3), .A_IN(a3_in), .B_IN(b3_in),
        .A_OUT(a3_out), .B_OUT(b3_out), .A_VLD(a3_vld), .B_VLD(b3_vld),
        .BUSY(busy3), .DONE(done3)
    );

    systolic_skew_feeder #(.WIDTH(8), .N(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .START(st4), .HOLD(hd4), .A_IN(a4_in), .B_IN(b4_in),
        .A_OUT(a4_out), .B_OUT(b4_out), .A_VLD(a4_vld), .B_VLD(b4_vld),
        .BUSY(busy4), .DONE(done4)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    endtask

    // Progress p counts unstalled edges since capture: data for step p-1 while 1<=p<=2N-1,
    // BUSY for 1<=p<=3N, DONE at p==3N. HOLD stalls progress until the DONE state (p=3N-1).
    task automatic model_step(input int s);
        int n, w;
        logic st, hd;
        logic [127:0] ain, bin, mask;
        n    = s ? 4 : 3;
        w    = s ? 8 : 4;
        st   = s ? st4 : st3;
        hd   = s ? hd4 : hd3;
        ain  = s ? a4_in : 128'(a3_in);
        bin  = s ? b4_in : 128'(b3_in);
        mask = (128'd1 << w) - 128'd1;
        if (mact[s]) begin
            if (!(hd && mp[s] <= 3 * n - 2)) mp[s]++;
            if (mp[s] > 3 * n) mact[s] = 1'b0;
        end else if (st) begin
            mact[s] = 1'b1;
            mp[s]   = 0;
            for (int i = 0; i < n; i++)
                for (int k = 0; k < n; k++) begin
                    ma[s][i][k] = int'((ain >> ((i * n + k) * w)) & mask);
                    mb[s][i][k] = int'((bin >> ((i * n + k) * w)) & mask);
                end
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mact[0] = 1'b0; mact[1] = 1'b0; mp[0] = 0; mp[1] = 0;
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    function automatic logic [31:0] exp_lanes(input int s, input bit isb, output logic [3:0] v);
        logic [31:0] r;
        int n, w, t, kk;
        r = '0; v = '0;
        n = s ? 4 : 3;
        w = s ? 8 : 4;
        t = mp[s] - 1;
        if (mact[s] && mp[s] >= 1 && mp[s] <= 2 * n - 1) begin
            for (int lane = 0; lane < n; lane++) begin
                kk = t - lane;
                if (kk >= 0 && kk < n) begin
                    r = r | (32'(isb ? mb[s][kk][lane] : ma[s][lane][kk]) << (lane * w));
                    v[lane] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic cmp(input int s, input logic [31:0] ao, input logic [31:0] bo,
                       input logic [3:0] av, input logic [3:0] bv, input logic bs,
                       input logic dn);
        logic [31:0] ea, eb;
        logic [3:0]  eav, ebv;
        int n;
        n  = s ? 4 : 3;
        ea = exp_lanes(s, 1'b0, eav);
        eb = exp_lanes(s, 1'b1, ebv);
        chk(s ? "n4_a_out" : "n3_a_out", ao, ea);
        chk(s ? "n4_b_out" : "n3_b_out", bo, eb);
        chk(s ? "n4_a_vld" : "n3_a_vld", 32'(av), 32'(eav));
        chk(s ? "n4_b_vld" : "n3_b_vld", 32'(bv), 32'(ebv));
        chk(s ? "n4_busy" : "n3_busy", 32'(bs), 32'(mact[s] && mp[s] >= 1 && mp[s] <= 3 * n));
        chk(s ? "n4_done" : "n3_done", 32'(dn), 32'(mact[s] && mp[s] == 3 * n));
    endtask

    always @(negedge CLK) begin
        cmp(0, 32'(a3_out), 32'(b3_out), {1'b0, a3_vld}, {1'b0, b3_vld}, busy3, done3);
        cmp(1, a4_out, b4_out, a4_vld, b4_vld, busy4, done4);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // A = [[1,2,3],[4,5,6],[7,8,9]], B = [[9,8,7],[6,5,4],[3,2,1]]
    task automatic load3_base();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) begin
                a3_in[(i*3+k)*4 +: 4] = 4'(3 * i + k + 1);
                b3_in[(i*3+k)*4 +: 4] = 4'(9 - (3 * i + k));
            end
    endtask

    task automatic start3();
        st3 = 1'b1;
        tick();
        st3 = 1'b0;
    endtask

    task automatic wait_done(input int s, input int c0, input int exp, input string nm);
        int c;
        logic d;
        c = c0;
        d = s ? done4 : done3;
        while (!d && c < 64) begin
            tick();
            c++;
            d = s ? done4 : done3;
        end
        chk(nm, 32'(c), 32'(exp));
    endtask

    logic [11:0] s2_a[5];
    logic [11:0] s2_b[5];
    logic [2:0]  s2_v[5];

    initial begin
        s2_a = '{12'h001, 12'h042, 12'h753, 12'h860, 12'h900};
        s2_b = '{12'h009, 12'h086, 12'h753, 12'h420, 12'h100};
        s2_v = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

        // Reset and idle
        repeat (3) tick();
        RST = 1'b0;
        repeat (3) tick();
        chk("idle_busy", 32'(busy3), 32'd0);
        chk("idle_a_out", 32'(a3_out), 32'd0);

        // Basic N=3 stream
        load3_base();
        start3();
        chk("s2_busy_c0", 32'(busy3), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("s2_a_lit", 32'(a3_out), 32'(s2_a[c-1]));
            chk("s2_b_lit", 32'(b3_out), 32'(s2_b[c-1]));
            chk("s2_vld_lit", 32'(a3_vld), 32'(s2_v[c-1]));
            chk("s2_busy_lit", 32'(busy3), 32'd1);
        end
        for (int c = 6; c <= 7; c++) begin
            tick();
            chk("s2_drain_lit", 32'({a3_out, b3_out, a3_vld, b3_vld}), 32'd0);
        end
        wait_done(0, 7, 9, "s2_done_cycle");
        repeat (2) tick();

        // HOLD for three edges at step 2
        load3_base();
        start3();
        repeat (3) tick();
        hd3 = 1'b1;
        for (int c = 4; c <= 6; c++) begin
            tick();
            chk("s3_hold_lit", 32'(a3_out), 32'h753);
        end
        hd3 = 1'b0;
        tick();
        chk("s3_resume_lit", 32'(a3_out), 32'h860);
        wait_done(0, 7, 12, "s3_done_cycle");
        repeat (2) tick();

        // START during FEED ignored; back-to-back START after DONE accepted
        load3_base();
        start3();
        repeat (2) tick();
        a3_in = 36'hFEDCBA987;
        st3   = 1'b1;
        tick();
        st3   = 1'b0;
        chk("s4_ignore_lit", 32'(a3_out), 32'h753);
        wait_done(0, 3, 9, "s4_done_cycle");
        tick();
        a3_in = 36'h123456789;
        b3_in = 36'h000000000;
        start3();
        tick();
        chk("s4_b2b_a_lit", 32'(a3_out), 32'h009);
        chk("s4_b2b_busy", 32'(busy3), 32'd1);
        wait_done(0, 1, 9, "s4_b2b_done_cycle");
        repeat (2) tick();

        // N=4, 8-bit, values up to 8'hFF
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a4_in[(i*4+k)*8 +: 8] = 8'(240 + i * 4 + k);
                b4_in[(k*4+i)*8 +: 8] = 8'(240 + i * 4 + k);
            end
        st4 = 1'b1;
        tick();
        st4 = 1'b0;
        repeat (3) tick();
        chk("s5_vld_c3", 32'(a4_vld), 32'h7);
        tick();
        chk("s5_vld_c4", 32'(a4_vld), 32'hF);
        chk("s5_lane3_first", 32'(a4_out[31:24]), 32'hFC);
        chk("s5_blane3_first", 32'(b4_out[31:24]), 32'hFC);
        repeat (3) tick();
        chk("s5_lane3_max", 32'(a4_out[31:24]), 32'hFF);
        chk("s5_blane3_max", 32'(b4_out[31:24]), 32'hFF);
        chk("s5_vld_c7", 32'(a4_vld), 32'h8);
        wait_done(1, 7, 12, "s5_done_cycle");
        repeat (2) tick();

        // Operand isolation: inputs churn every cycle of the operation
        load3_base();
        start3();
        for (int c = 1; c <= 8; c++) begin
            a3_in = 36'({$urandom(), $urandom()});
            b3_in = 36'({$urandom(), $urandom()});
            tick();
            if (c == 3) chk("s6_iso_lit", 32'(a3_out), 32'h753);
        end
        wait_done(0, 8, 9, "s6_done_cycle");
        repeat (2) tick();

        // Asynchronous reset mid-FEED
        load3_base();
        start3();
        repeat (2) tick();
        #2 RST = 1'b1;
        #1;
        chk("s1_rst_a_out", 32'({a3_out, a3_vld}), 32'd0);
        chk("s1_rst_busy", 32'(busy3), 32'd0);
        tick();
        RST = 1'b0;
        repeat (12) tick();
        chk("s1_post_busy", 32'(busy3), 32'd0);
        chk("s1_post_done", 32'(done3), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
